// File: rtl/ic_router_n_if.sv
`default_nettype none
// ============================================================================
// Module  : ic_cpu_if / ic_tgt_if
// Brief   : Bus bundles for the single-initiator memory router.
//           ic_cpu_if carries one CPU memory port (req/gnt, recv/ack).
//           ic_tgt_if carries NT flattened target ports.
//           master = side that issues requests, slave = side that answers.
// Revision: 1.0 - initial release
// ============================================================================

interface ic_cpu_if;
    logic        req;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        gnt;
    logic        recv;
    logic        ack;
    logic        error;
    logic [31:0] rdata;

    modport master (
        output req, wen, strb, wdata, addr, ack,
        input  gnt, recv, error, rdata
    );

    modport slave (
        input  req, wen, strb, wdata, addr, ack,
        output gnt, recv, error, rdata
    );
endinterface

interface ic_tgt_if #(
    parameter int NT = 3
);
    logic [NT-1:0]    req;
    logic [NT-1:0]    wen;
    logic [4*NT-1:0]  strb;
    logic [32*NT-1:0] wdata;
    logic [32*NT-1:0] addr;
    logic [NT-1:0]    gnt;
    logic [NT-1:0]    recv;
    logic [NT-1:0]    ack;
    logic [NT-1:0]    error;
    logic [32*NT-1:0] rdata;

    modport master (
        output req, wen, strb, wdata, addr, ack,
        input  gnt, recv, error, rdata
    );

    modport slave (
        input  req, wen, strb, wdata, addr, ack,
        output gnt, recv, error, rdata
    );
endinterface

`default_nettype wire

// File: rtl/ic_router_n.sv
`default_nettype none
// ============================================================================
// Module  : ic_router_n
// Brief   : Parametrised single-initiator memory router. Decodes one CPU
//           memory port onto NT targets through a match/mask address map,
//           keeps up to OUTSTANDING requests in flight in order with a
//           route-ID FIFO, and answers unmapped addresses with an internal
//           error responder (ID = NT).
// Revision: 1.0 - initial release
// ============================================================================

module ic_router_n #(
    parameter int              NT          = 3,
    parameter int              OUTSTANDING = 2,
    parameter logic [32*NT-1:0] MAP_MATCH  = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [32*NT-1:0] MAP_MASK   = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_C000}
) (
    input  wire logic  g_clk,
    input  wire logic  g_resetn,
    ic_cpu_if.slave    cpu,
    ic_tgt_if.master   tgt
);

    localparam int ID_W  = $clog2(NT + 1);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    localparam logic [ID_W-1:0]  ERR_ID   = ID_W'(NT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

    // Route FIFO state
    logic [ID_W-1:0]  r_fifo [OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [ID_W-1:0]  r_last;

    logic [ID_W-1:0]  w_sel;
    logic [ID_W-1:0]  w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_ok;
    logic             w_sel_gnt;
    logic             w_gnt;
    logic             w_push;
    logic             w_pop;
    logic             w_recv;
    logic             w_error;
    logic [31:0]      w_rdata;
    logic [NT-1:0]    w_tgt_req;
    logic [NT-1:0]    w_tgt_ack;

    // Wrap modulo OUTSTANDING so non-power-of-2 depths work
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Address decode: scan downwards so the lowest matching target wins
    always_comb begin
        w_sel = ERR_ID;
        for (int i = NT - 1; i >= 0; i--) begin
            if ((cpu.addr & MAP_MASK[32*i +: 32]) == MAP_MATCH[32*i +: 32]) begin
                w_sel = ID_W'(i);
            end
        end
    end

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    // Switching targets only when the FIFO has drained keeps responses ordered
    assign w_ok    = !w_full && (w_empty || (r_last == w_sel));
    assign w_head  = r_fifo[r_rd_ptr];

    // Request routing and grant select; the error responder always grants
    always_comb begin
        w_sel_gnt = 1'b0;
        w_tgt_req = '0;
        for (int i = 0; i < NT; i++) begin
            if (w_sel == ID_W'(i)) begin
                w_sel_gnt    = tgt.gnt[i];
                w_tgt_req[i] = g_resetn && cpu.req && w_ok;
            end
        end
        if (w_sel == ERR_ID) begin
            w_sel_gnt = 1'b1;
        end
    end

    assign w_gnt  = g_resetn && cpu.req && w_ok && w_sel_gnt;
    assign w_push = cpu.req && w_gnt;

    // Response mux from the FIFO head; head == ERR_ID answers immediately
    always_comb begin
        w_recv    = 1'b0;
        w_error   = 1'b0;
        w_rdata   = '0;
        w_tgt_ack = '0;
        if (g_resetn && !w_empty) begin
            if (w_head == ERR_ID) begin
                w_recv  = 1'b1;
                w_error = 1'b1;
            end else begin
                for (int i = 0; i < NT; i++) begin
                    if (w_head == ID_W'(i)) begin
                        w_recv       = tgt.recv[i];
                        w_error      = tgt.error[i];
                        w_rdata      = tgt.rdata[32*i +: 32];
                        w_tgt_ack[i] = cpu.ack;
                    end
                end
            end
        end
    end

    assign w_pop = w_recv && cpu.ack;

    // Route FIFO bookkeeping; storage itself needs no reset since count gates it
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= ptr_next(r_wr_ptr);
                r_last           <= w_sel;
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign cpu.gnt   = w_gnt;
    assign cpu.recv  = w_recv;
    assign cpu.error = w_error;
    assign cpu.rdata = w_rdata;

    assign tgt.req   = w_tgt_req;
    assign tgt.ack   = w_tgt_ack;
    assign tgt.wen   = {NT{cpu.wen}};
    assign tgt.strb  = {NT{cpu.strb}};
    assign tgt.wdata = {NT{cpu.wdata}};
    assign tgt.addr  = {NT{cpu.addr}};

endmodule

`default_nettype wire
